ftq_redirect_read_pipe: RTL and testbench

FTQ_REDIRECT_READ_PIPE -- requirements
Module: ftq_redirect_read_pipe

---
 rtl/ftq_redirect_pkg.sv | 32 +++
 rtl/ftq_redirect_read_pipe_if.sv | 50 +++++
 rtl/ftq_redirect_skid_q.sv | 43 ++++
 rtl/ftq_redirect_read_pipe.sv | 98 +++++++++
 tb/tb_ftq_redirect_read_pipe.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/ftq_redirect_pkg.sv
// Shared widths, the packed redirect-meta layout and small helpers for the
// FTQ redirect read pipe.
package ftq_redirect_pkg;

   localparam int ENTRIES = 64;
   localparam int IDX_W   = 6;
   localparam int META_W  = 84;

   typedef struct packed {
      logic       hist_ptr_flag;
      logic [7:0] hist_ptr_value;
      logic [3:0] ssp;
      logic [2:0] sctr;
      logic       tosw_flag;
      logic [4:0] tosw_value;
      logic       tosr_flag;
      logic [4:0] tosr_value;
      logic       nos_flag;
      logic [4:0] nos_value;
      logic [49:0] top_addr;
   } redirect_meta_t;

   typedef enum logic {
      SRC_BACKEND = 1'b0,
      SRC_IFU     = 1'b1
   } redirect_src_e;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/ftq_redirect_read_pipe_if.sv
// Request, memory, snoop and recovery-packet signals of the redirect read pipe.
interface ftq_redirect_read_pipe_if import ftq_redirect_pkg::*; #(
   parameter int IDX_W  = ftq_redirect_pkg::IDX_W,
   parameter int META_W = ftq_redirect_pkg::META_W
);
   logic              io_bkRedirect_valid;
   logic              io_bkRedirect_ftqIdx_flag;
   logic [IDX_W-1:0]  io_bkRedirect_ftqIdx_value;
   logic              io_ifuRedirect_valid;
   logic              io_ifuRedirect_ready;
   logic              io_ifuRedirect_ftqIdx_flag;
   logic [IDX_W-1:0]  io_ifuRedirect_ftqIdx_value;
   logic              io_mem_ren;
   logic [IDX_W-1:0]  io_mem_raddr;
   logic [META_W-1:0] io_mem_rdata;
   logic              io_snoop_wen;
   logic [IDX_W-1:0]  io_snoop_waddr;
   logic [META_W-1:0] io_snoop_wdata;
   logic              io_out_valid;
   logic              io_out_ready;
   logic              io_out_src;
   logic              io_out_ftqIdx_flag;
   logic [IDX_W-1:0]  io_out_ftqIdx_value;
   logic [META_W-1:0] io_out_meta;
   logic [7:0]        io_ifuDropCnt;

   modport master (
      output io_bkRedirect_valid, io_bkRedirect_ftqIdx_flag, io_bkRedirect_ftqIdx_value,
      output io_ifuRedirect_valid, io_ifuRedirect_ftqIdx_flag, io_ifuRedirect_ftqIdx_value,
      input  io_ifuRedirect_ready,
      input  io_mem_ren, io_mem_raddr,
      output io_mem_rdata,
      output io_snoop_wen, io_snoop_waddr, io_snoop_wdata,
      input  io_out_valid, io_out_src, io_out_ftqIdx_flag, io_out_ftqIdx_value, io_out_meta,
      output io_out_ready,
      input  io_ifuDropCnt
   );

   modport slave (
      input  io_bkRedirect_valid, io_bkRedirect_ftqIdx_flag, io_bkRedirect_ftqIdx_value,
      input  io_ifuRedirect_valid, io_ifuRedirect_ftqIdx_flag, io_ifuRedirect_ftqIdx_value,
      output io_ifuRedirect_ready,
      output io_mem_ren, io_mem_raddr,
      input  io_mem_rdata,
      input  io_snoop_wen, io_snoop_waddr, io_snoop_wdata,
      output io_out_valid, io_out_src, io_out_ftqIdx_flag, io_out_ftqIdx_value, io_out_meta,
      input  io_out_ready,
      output io_ifuDropCnt
   );
endinterface

// File: rtl/ftq_redirect_skid_q.sv
// Two-entry packet FIFO with synchronous flush; a full queue still accepts
// an enqueue when the head pops in the same cycle.
module ftq_redirect_skid_q import ftq_redirect_pkg::*; #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush,
   input  logic             enq_valid,
   input  logic [WIDTH-1:0] enq_data,
   output logic             head_valid,
   output logic [WIDTH-1:0] head_data,
   input  logic             deq_ready,
   output logic [1:0]       count
);
   logic [WIDTH-1:0] slot [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic             deq;
   logic             enq;

   assign head_valid = (count != 2'd0);
   assign head_data  = slot[rd_ptr];
   assign deq        = head_valid && deq_ready;
   assign enq        = enq_valid && ((count != 2'd2) || deq);

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         count  <= 2'd0;
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
      end else begin
         if (enq) wr_ptr <= ~wr_ptr;
         if (deq) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, enq} - {1'b0, deq};
      end
   end

   always_ff @(posedge clock) begin
      if (enq && !flush) slot[wr_ptr] <= enq_data;
   end

endmodule

// File: rtl/ftq_redirect_read_pipe.sv
// Reads redirect meta for backend/IFU redirects, forwards same-cycle snoop
// writes, and queues recovery packets; a backend redirect supersedes all.
module ftq_redirect_read_pipe import ftq_redirect_pkg::*; #(
   parameter int ENTRIES = ftq_redirect_pkg::ENTRIES,
   parameter int IDX_W   = ftq_redirect_pkg::IDX_W,
   parameter int META_W  = ftq_redirect_pkg::META_W
) (
   input  logic                   clock,
   input  logic                   reset,
   ftq_redirect_read_pipe_if.slave bus
);
   localparam int PKT_W = 2 + IDX_W + META_W;

   logic              bk_accept;
   logic              ifu_ready;
   logic              ifu_accept;
   logic              accept;
   logic              acc_flag;
   logic [IDX_W-1:0]  acc_value;
   logic              fwd_hit;
   logic              credit;

   logic              s1_valid;
   redirect_src_e     s1_src;
   logic              s1_flag;
   logic [IDX_W-1:0]  s1_value;
   logic              s1_fwd;
   logic [META_W-1:0] s1_snoop_data;
   logic [META_W-1:0] s1_meta;

   logic [1:0]        q_count;
   logic              q_head_valid;
   logic [PKT_W-1:0]  q_head_data;
   logic [7:0]        drop_cnt;

   // S1 and queued packets both consume IFU credit; the backend never waits.
   assign credit     = ({1'b0, q_count} + {2'b00, s1_valid}) < 3'd2;
   assign bk_accept  = bus.io_bkRedirect_valid && !reset;
   assign ifu_ready  = !reset && !bus.io_bkRedirect_valid && credit;
   assign ifu_accept = bus.io_ifuRedirect_valid && ifu_ready;
   assign accept     = bk_accept || ifu_accept;

   assign acc_value = bk_accept  ? bus.io_bkRedirect_ftqIdx_value  :
                      ifu_accept ? bus.io_ifuRedirect_ftqIdx_value : '0;
   assign acc_flag  = bk_accept  ? bus.io_bkRedirect_ftqIdx_flag   :
                      ifu_accept ? bus.io_ifuRedirect_ftqIdx_flag  : 1'b0;

   // A write to a slot beyond the populated entries never lands in memory.
   assign fwd_hit = accept && bus.io_snoop_wen &&
                    (bus.io_snoop_waddr == acc_value) && (int'(acc_value) < ENTRIES);

   assign bus.io_ifuRedirect_ready = ifu_ready;
   assign bus.io_mem_ren           = accept;
   assign bus.io_mem_raddr         = acc_value;

   always_ff @(posedge clock) begin
      if (reset) s1_valid <= 1'b0;
      else       s1_valid <= accept;
   end

   always_ff @(posedge clock) begin
      if (accept) begin
         s1_src   <= bk_accept ? SRC_BACKEND : SRC_IFU;
         s1_flag  <= acc_flag;
         s1_value <= acc_value;
         s1_fwd   <= fwd_hit;
      end
      if (fwd_hit) s1_snoop_data <= bus.io_snoop_wdata;
   end

   assign s1_meta = s1_fwd ? s1_snoop_data : bus.io_mem_rdata;

   ftq_redirect_skid_q #(.WIDTH(PKT_W)) u_skid_q (
      .clock      (clock),
      .reset      (reset),
      .flush      (bk_accept),
      .enq_valid  (s1_valid && !bk_accept),
      .enq_data   ({s1_src, s1_flag, s1_value, s1_meta}),
      .head_valid (q_head_valid),
      .head_data  (q_head_data),
      .deq_ready  (bus.io_out_ready),
      .count      (q_count)
   );

   assign bus.io_out_valid = q_head_valid;
   assign {bus.io_out_src, bus.io_out_ftqIdx_flag,
           bus.io_out_ftqIdx_value, bus.io_out_meta} = q_head_data;

   always_ff @(posedge clock) begin
      if (reset)
         drop_cnt <= 8'd0;
      else if (bus.io_ifuRedirect_valid && bus.io_bkRedirect_valid)
         drop_cnt <= sat_inc8(drop_cnt);
   end

   assign bus.io_ifuDropCnt = drop_cnt;

endmodule

// File: tb/tb_ftq_redirect_read_pipe.sv
// Randomized and directed bench for the redirect read pipe against a
// packet-level model: a list of accepted redirects, each visible two cycles on.
module tb_ftq_redirect_read_pipe;
   import ftq_redirect_pkg::*;

   logic clock    = 1'b0;
   logic reset    = 1'b1;
   logic mem_load = 1'b1;

   always #5 clock = ~clock;

   ftq_redirect_read_pipe_if #(.IDX_W(IDX_W), .META_W(META_W)) bus ();

   ftq_redirect_read_pipe #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .META_W(META_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // Redirect-meta memory: registered read, read-during-write returns old data.
   logic [META_W-1:0] mem [ENTRIES];
   always @(posedge clock) begin
      if (mem_load) begin
         for (int i = 0; i < ENTRIES; i++) mem[i] <= META_W'({$urandom, $urandom, $urandom});
      end else if (bus.io_snoop_wen) begin
         mem[bus.io_snoop_waddr] <= bus.io_snoop_wdata;
      end
      if (bus.io_mem_ren) bus.io_mem_rdata <= mem[bus.io_mem_raddr];
   end

   typedef struct {
      logic              src;
      logic              flag;
      logic [IDX_W-1:0]  value;
      logic [META_W-1:0] meta;
      int                acc;
   } exp_pkt_t;

   exp_pkt_t         mq[$];
   int               now = 0;
   int               drop_m = 0;
   int               n_checks = 0;
   int               n_errors = 0;
   int               ifu_acc_seen = 0;
   int               n_pop = 0;
   int               base;
   logic [IDX_W-1:0] last_pop_value = '0;

   localparam logic [META_W-1:0] PAT_A5 = META_W'({11{8'hA5}});
   localparam logic [META_W-1:0] PAT_3C = META_W'({11{8'h3C}});

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cycle(input logic rst,
                        input logic bk_v, input logic bk_f, input logic [IDX_W-1:0] bk_i,
                        input logic ifu_v, input logic ifu_f, input logic [IDX_W-1:0] ifu_i,
                        input logic wen, input logic [IDX_W-1:0] wa, input logic [META_W-1:0] wd,
                        input logic ordy);
      logic             exp_ready, bk_acc, ifu_acc, acc, head_vis;
      logic [IDX_W-1:0] acc_i;
      exp_pkt_t         p;
      reset                           = rst;
      bus.io_bkRedirect_valid         = bk_v;
      bus.io_bkRedirect_ftqIdx_flag   = bk_f;
      bus.io_bkRedirect_ftqIdx_value  = bk_i;
      bus.io_ifuRedirect_valid        = ifu_v;
      bus.io_ifuRedirect_ftqIdx_flag  = ifu_f;
      bus.io_ifuRedirect_ftqIdx_value = ifu_i;
      bus.io_snoop_wen                = wen;
      bus.io_snoop_waddr              = wa;
      bus.io_snoop_wdata              = wd;
      bus.io_out_ready                = ordy;
      @(negedge clock);
      exp_ready = !rst && !bk_v && (mq.size() < 2);
      bk_acc    = !rst && bk_v;
      ifu_acc   = ifu_v && exp_ready;
      acc       = bk_acc || ifu_acc;
      acc_i     = bk_acc ? bk_i : (ifu_acc ? ifu_i : '0);
      head_vis  = (mq.size() > 0) && (mq[0].acc <= now - 2);
      check_val("ifu_ready", bus.io_ifuRedirect_ready, exp_ready);
      check_val("mem_ren", bus.io_mem_ren, acc);
      check_val("mem_raddr", bus.io_mem_raddr, acc_i);
      check_val("out_valid", bus.io_out_valid, head_vis);
      check_val("drop_cnt", bus.io_ifuDropCnt, 128'(drop_m));
      if (head_vis) begin
         check_val("out_src", bus.io_out_src, mq[0].src);
         check_val("out_flag", bus.io_out_ftqIdx_flag, mq[0].flag);
         check_val("out_value", bus.io_out_ftqIdx_value, mq[0].value);
         check_val("out_meta", bus.io_out_meta, mq[0].meta);
      end
      if (bus.io_ifuRedirect_valid && bus.io_ifuRedirect_ready) ifu_acc_seen++;
      if (bus.io_out_valid && ordy) begin
         n_pop++;
         last_pop_value = bus.io_out_ftqIdx_value;
      end
      if (rst) begin
         mq.delete();
         drop_m = 0;
      end else begin
         if (head_vis && ordy) void'(mq.pop_front());
         if (bk_acc) mq.delete();
         if (acc) begin
            p.src   = ifu_acc;
            p.flag  = bk_acc ? bk_f : ifu_f;
            p.value = acc_i;
            p.meta  = (wen && wa == acc_i) ? wd : mem[acc_i];
            p.acc   = now;
            mq.push_back(p);
         end
         if (bk_v && ifu_v && drop_m < 255) drop_m++;
      end
      now++;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input logic ordy);
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, ordy);
   endtask

   task automatic rand_cycle(input int bk_pct, input int rst_pct);
      cycle(($urandom_range(0, 99) < rst_pct),
            ($urandom_range(0, 99) < bk_pct), 1'($urandom), IDX_W'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 60), 1'($urandom), IDX_W'($urandom_range(0, 7)),
            ($urandom_range(0, 99) < 35), IDX_W'($urandom_range(0, 7)),
            META_W'({$urandom, $urandom, $urandom}),
            ($urandom_range(0, 99) < 70));
   endtask

   initial begin
      bus.io_bkRedirect_valid         = 1'b0;
      bus.io_bkRedirect_ftqIdx_flag   = 1'b0;
      bus.io_bkRedirect_ftqIdx_value  = '0;
      bus.io_ifuRedirect_valid        = 1'b0;
      bus.io_ifuRedirect_ftqIdx_flag  = 1'b0;
      bus.io_ifuRedirect_ftqIdx_value = '0;
      bus.io_snoop_wen                = 1'b0;
      bus.io_snoop_waddr              = '0;
      bus.io_snoop_wdata              = '0;
      bus.io_out_ready                = 1'b0;
      repeat (2) @(posedge clock);
      mem_load = 1'b0;
      #1;

      // reset state
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      check_val("rst_out_valid", bus.io_out_valid, 1'b0);
      check_val("rst_drop", bus.io_ifuDropCnt, 8'd0);

      // backend basic: idx 5 with mem[5] seeded via a snoop write
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b1, IDX_W'(5), PAT_A5, 1'b1);
      cycle(1'b0, 1'b1, 1'b1, IDX_W'(5), 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
      idle(1'b1);
      check_val("bk_out_valid", bus.io_out_valid, 1'b1);
      check_val("bk_out_meta", bus.io_out_meta, PAT_A5);
      check_val("bk_out_src", bus.io_out_src, 1'b0);
      idle(1'b1);

      // forwarding: IFU idx 9 with a same-cycle snoop write to 9
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, IDX_W'(9), 1'b1, IDX_W'(9), PAT_3C, 1'b1);
      idle(1'b1);
      check_val("fwd_out_meta", bus.io_out_meta, PAT_3C);
      check_val("fwd_out_value", bus.io_out_ftqIdx_value, 9);
      idle(1'b1);

      // credit: consumer stalled, IFU requesting every cycle
      base = ifu_acc_seen;
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, IDX_W'(1), 1'b0, '0, '0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, IDX_W'(2), 1'b0, '0, '0, 1'b0);
      repeat (4) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b1, IDX_W'(3), 1'b0, '0, '0, 1'b0);
      check_val("credit_accepts", 128'(ifu_acc_seen - base), 2);
      check_val("credit_ready", bus.io_ifuRedirect_ready, 1'b0);
      check_val("credit_drop", bus.io_ifuDropCnt, 8'd0);

      // supersede: backend idx 7 over a full queue
      base = n_pop;
      cycle(1'b0, 1'b1, 1'b0, IDX_W'(7), 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0);
      repeat (6) idle(1'b1);
      check_val("supersede_pops", 128'(n_pop - base), 1);
      check_val("supersede_idx", last_pop_value, 7);

      // reset one cycle after accept
      base = n_pop;
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, IDX_W'(12), 1'b0, '0, '0, 1'b1);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1);
      repeat (4) begin
         check_val("midrst_out_valid", bus.io_out_valid, 1'b0);
         idle(1'b1);
      end
      check_val("midrst_pops", 128'(n_pop - base), 0);

      // random traffic
      repeat (1500) rand_cycle(10, 1);

      // collision saturation
      repeat (300) cycle(1'b0, 1'b1, 1'($urandom), IDX_W'($urandom), 1'b1, 1'($urandom),
                         IDX_W'($urandom), 1'b0, '0, '0, 1'($urandom));
      check_val("drop_sat", bus.io_ifuDropCnt, 8'd255);
      idle(1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
